// File: rtl/m_ext_reservation_station_if.sv
// Issue, CDB, dispatch and flush bundle for the M-extension reservation station.
// The slave modport is the station; master is the surrounding pipeline.
interface m_ext_reservation_station_if #(
  parameter int XLEN                = 64,
  parameter int ROB_INDEX_WIDTH     = 8,
  parameter int DECODED_INSTR_WIDTH = 6
);
  logic                           issue_valid_i;
  logic                           issue_ready_o;
  logic [DECODED_INSTR_WIDTH-1:0] issue_decoded_instruction_i;
  logic [ROB_INDEX_WIDTH-1:0]     issue_ROB_index_i;
  logic                           issue_1st_valid_i;
  logic [XLEN-1:0]                issue_1st_value_i;
  logic [ROB_INDEX_WIDTH-1:0]     issue_1st_tag_i;
  logic                           issue_2nd_valid_i;
  logic [XLEN-1:0]                issue_2nd_value_i;
  logic [ROB_INDEX_WIDTH-1:0]     issue_2nd_tag_i;
  logic                           cdb_valid_i;
  logic [ROB_INDEX_WIDTH-1:0]     cdb_ROB_index_i;
  logic [XLEN-1:0]                cdb_value_i;
  logic                           dispatch_valid_o;
  logic                           dispatch_ready_i;
  logic [XLEN-1:0]                dispatch_1st_reg_o;
  logic [XLEN-1:0]                dispatch_2nd_reg_o;
  logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction_o;
  logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index_o;
  logic                           flush_i;

  modport master (
    output issue_valid_i, issue_decoded_instruction_i, issue_ROB_index_i,
           issue_1st_valid_i, issue_1st_value_i, issue_1st_tag_i,
           issue_2nd_valid_i, issue_2nd_value_i, issue_2nd_tag_i,
           cdb_valid_i, cdb_ROB_index_i, cdb_value_i, dispatch_ready_i, flush_i,
    input  issue_ready_o, dispatch_valid_o, dispatch_1st_reg_o, dispatch_2nd_reg_o,
           dispatch_decoded_instruction_o, dispatch_ROB_index_o
  );

  modport slave (
    input  issue_valid_i, issue_decoded_instruction_i, issue_ROB_index_i,
           issue_1st_valid_i, issue_1st_value_i, issue_1st_tag_i,
           issue_2nd_valid_i, issue_2nd_value_i, issue_2nd_tag_i,
           cdb_valid_i, cdb_ROB_index_i, cdb_value_i, dispatch_ready_i, flush_i,
    output issue_ready_o, dispatch_valid_o, dispatch_1st_reg_o, dispatch_2nd_reg_o,
           dispatch_decoded_instruction_o, dispatch_ROB_index_o
  );
endinterface

// File: rtl/m_ext_reservation_station.sv
// Reservation station for the M-extension lane: holds ops until both operands
// arrive (direct or via CDB snoop) and dispatches the oldest ready one.
module m_ext_reservation_station #(
  parameter int XLEN                = 64,
  parameter int ROB_INDEX_WIDTH     = 8,
  parameter int DECODED_INSTR_WIDTH = 6,
  parameter int RS_SLOTS            = 4
) (
  input logic                        clock_i,
  input logic                        reset_i,
  m_ext_reservation_station_if.slave bus
);
  typedef logic [RS_SLOTS-1:0] mask_t;

  mask_t                          slot_valid, rdy1, rdy2, elig, sel, free_oh;
  // older[i][j] set means slot i was issued before slot j
  mask_t                          older [RS_SLOTS];
  logic [XLEN-1:0]                val1  [RS_SLOTS];
  logic [XLEN-1:0]                val2  [RS_SLOTS];
  logic [ROB_INDEX_WIDTH-1:0]     tag1  [RS_SLOTS];
  logic [ROB_INDEX_WIDTH-1:0]     tag2  [RS_SLOTS];
  logic [ROB_INDEX_WIDTH-1:0]     rob   [RS_SLOTS];
  logic [DECODED_INSTR_WIDTH-1:0] op    [RS_SLOTS];

  logic                           out_valid;
  logic [XLEN-1:0]                out_val1, out_val2, sel_val1, sel_val2;
  logic [ROB_INDEX_WIDTH-1:0]     out_rob, sel_rob;
  logic [DECODED_INSTR_WIDTH-1:0] out_op, sel_op;
  logic                           issue_ready, accept, load, hit1, hit2;

  assign issue_ready = ~&slot_valid;
  assign accept      = bus.issue_valid_i & issue_ready & ~bus.flush_i;
  assign load        = ~bus.flush_i & (|elig) & (~out_valid | bus.dispatch_ready_i);
  assign hit1        = bus.cdb_valid_i & (bus.cdb_ROB_index_i == bus.issue_1st_tag_i);
  assign hit2        = bus.cdb_valid_i & (bus.cdb_ROB_index_i == bus.issue_2nd_tag_i);

  always_comb begin
    free_oh = ~slot_valid & mask_t'(slot_valid + mask_t'(1));
    elig    = slot_valid & rdy1 & rdy2;
    sel     = '0;
    for (int i = 0; i < RS_SLOTS; i++) begin
      sel[i] = elig[i];
      for (int j = 0; j < RS_SLOTS; j++)
        if (j != i && elig[j] && !older[i][j]) sel[i] = 1'b0;
    end
  end

  always_comb begin
    sel_val1 = '0;
    sel_val2 = '0;
    sel_rob  = '0;
    sel_op   = '0;
    for (int i = 0; i < RS_SLOTS; i++) begin
      if (sel[i]) begin
        sel_val1 = val1[i];
        sel_val2 = val2[i];
        sel_rob  = rob[i];
        sel_op   = op[i];
      end
    end
  end

  // Slot payload: only meaningful while slot_valid is set, so it carries no reset
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < RS_SLOTS; i++) begin
      if (bus.cdb_valid_i && slot_valid[i]) begin
        if (!rdy1[i] && tag1[i] == bus.cdb_ROB_index_i) begin
          rdy1[i] <= 1'b1;
          val1[i] <= bus.cdb_value_i;
        end
        if (!rdy2[i] && tag2[i] == bus.cdb_ROB_index_i) begin
          rdy2[i] <= 1'b1;
          val2[i] <= bus.cdb_value_i;
        end
      end
      if (accept && free_oh[i]) begin
        op[i]    <= bus.issue_decoded_instruction_i;
        rob[i]   <= bus.issue_ROB_index_i;
        tag1[i]  <= bus.issue_1st_tag_i;
        tag2[i]  <= bus.issue_2nd_tag_i;
        rdy1[i]  <= bus.issue_1st_valid_i | hit1;
        rdy2[i]  <= bus.issue_2nd_valid_i | hit2;
        val1[i]  <= bus.issue_1st_valid_i ? bus.issue_1st_value_i : bus.cdb_value_i;
        val2[i]  <= bus.issue_2nd_valid_i ? bus.issue_2nd_value_i : bus.cdb_value_i;
        older[i] <= '0;
        for (int j = 0; j < RS_SLOTS; j++)
          if (j != i) older[j][i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || bus.flush_i) begin
      slot_valid <= '0;
      out_valid  <= 1'b0;
      out_val1   <= '0;
      out_val2   <= '0;
      out_rob    <= '0;
      out_op     <= '0;
    end else begin
      slot_valid <= (slot_valid & ~(load ? sel : mask_t'(0))) | (accept ? free_oh : mask_t'(0));
      if (load) begin
        out_valid <= 1'b1;
        out_val1  <= sel_val1;
        out_val2  <= sel_val2;
        out_rob   <= sel_rob;
        out_op    <= sel_op;
      end else if (bus.dispatch_ready_i) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.issue_ready_o                  = issue_ready;
  assign bus.dispatch_valid_o               = out_valid;
  assign bus.dispatch_1st_reg_o             = out_val1;
  assign bus.dispatch_2nd_reg_o             = out_val2;
  assign bus.dispatch_ROB_index_o           = out_rob;
  assign bus.dispatch_decoded_instruction_o = out_op;
endmodule

// File: tb/tb_m_ext_reservation_station.sv
// Directed bench for m_ext_reservation_station with an age-ordered queue model
// compared against the DUT on every falling edge.
module tb_m_ext_reservation_station;
  localparam int SLOTS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  m_ext_reservation_station_if #(.XLEN(64), .ROB_INDEX_WIDTH(8), .DECODED_INSTR_WIDTH(6)) bus ();

  m_ext_reservation_station #(
    .XLEN(64), .ROB_INDEX_WIDTH(8), .DECODED_INSTR_WIDTH(6), .RS_SLOTS(SLOTS)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entries kept in issue order, so the oldest ready one is the first hit
  typedef struct packed {
    logic [5:0]  op;
    logic [7:0]  rob;
    logic        r1;
    logic [63:0] v1;
    logic [7:0]  t1;
    logic        r2;
    logic [63:0] v2;
    logic [7:0]  t2;
  } ent_t;

  ent_t q[$];
  ent_t m_out;
  ent_t e;
  logic m_ov = 1'b0;
  logic started = 1'b0;
  int   pick;
  int   n0;

  always @(posedge clk) begin
    if (rst || bus.flush_i) begin
      q.delete();
      m_ov    = 1'b0;
      m_out   = '0;
      started = 1'b1;
    end else begin
      n0   = q.size();
      pick = -1;
      for (int i = 0; i < q.size(); i++)
        if (q[i].r1 && q[i].r2) begin pick = i; break; end
      if ((!m_ov || bus.dispatch_ready_i) && pick >= 0) begin
        m_out = q[pick];
        m_ov  = 1'b1;
        q.delete(pick);
      end else if (bus.dispatch_ready_i) begin
        m_ov = 1'b0;
      end
      if (bus.cdb_valid_i) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].r1 && q[i].t1 == bus.cdb_ROB_index_i) begin q[i].r1 = 1'b1; q[i].v1 = bus.cdb_value_i; end
          if (!q[i].r2 && q[i].t2 == bus.cdb_ROB_index_i) begin q[i].r2 = 1'b1; q[i].v2 = bus.cdb_value_i; end
        end
      end
      if (bus.issue_valid_i && n0 < SLOTS) begin
        e.op  = bus.issue_decoded_instruction_i;
        e.rob = bus.issue_ROB_index_i;
        e.t1  = bus.issue_1st_tag_i;
        e.t2  = bus.issue_2nd_tag_i;
        e.r1  = bus.issue_1st_valid_i || (bus.cdb_valid_i && bus.cdb_ROB_index_i == e.t1);
        e.r2  = bus.issue_2nd_valid_i || (bus.cdb_valid_i && bus.cdb_ROB_index_i == e.t2);
        e.v1  = bus.issue_1st_valid_i ? bus.issue_1st_value_i : bus.cdb_value_i;
        e.v2  = bus.issue_2nd_valid_i ? bus.issue_2nd_value_i : bus.cdb_value_i;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m.issue_ready", 64'(bus.issue_ready_o), 64'(q.size() < SLOTS));
      chk("m.valid", 64'(bus.dispatch_valid_o), 64'(m_ov));
      chk("m.reg1", bus.dispatch_1st_reg_o, m_out.v1);
      chk("m.reg2", bus.dispatch_2nd_reg_o, m_out.v2);
      chk("m.rob", 64'(bus.dispatch_ROB_index_o), 64'(m_out.rob));
      chk("m.op", 64'(bus.dispatch_decoded_instruction_o), 64'(m_out.op));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] rob, input logic [5:0] op,
                       input logic ok1, input logic [63:0] v1, input logic [7:0] t1,
                       input logic ok2, input logic [63:0] v2, input logic [7:0] t2);
    bus.issue_valid_i               = 1'b1;
    bus.issue_ROB_index_i           = rob;
    bus.issue_decoded_instruction_i = op;
    bus.issue_1st_valid_i           = ok1;
    bus.issue_1st_value_i           = v1;
    bus.issue_1st_tag_i             = t1;
    bus.issue_2nd_valid_i           = ok2;
    bus.issue_2nd_value_i           = v2;
    bus.issue_2nd_tag_i             = t2;
  endtask

  task automatic cdb(input logic v, input logic [7:0] idx, input logic [63:0] val);
    bus.cdb_valid_i     = v;
    bus.cdb_ROB_index_i = idx;
    bus.cdb_value_i     = val;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [7:0] rob,
                            input logic [63:0] r1, input logic [63:0] r2);
    chk({name, ".valid"}, 64'(bus.dispatch_valid_o), 64'(v));
    if (v) begin
      chk({name, ".rob"}, 64'(bus.dispatch_ROB_index_o), 64'(rob));
      chk({name, ".reg1"}, bus.dispatch_1st_reg_o, r1);
      chk({name, ".reg2"}, bus.dispatch_2nd_reg_o, r2);
    end
  endtask

  initial begin
    issue(8'd0, 6'd0, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0, 8'd0);
    bus.issue_valid_i    = 1'b0;
    bus.dispatch_ready_i = 1'b1;
    bus.flush_i          = 1'b0;
    cdb(1'b0, 8'd0, 64'd0);

    // reset together with flush
    rst = 1'b1; bus.flush_i = 1'b1;
    tick();
    rst = 1'b0; bus.flush_i = 1'b0;
    chk("rst.issue_ready", 64'(bus.issue_ready_o), 64'd1);
    chk("rst.valid", 64'(bus.dispatch_valid_o), 64'd0);
    chk("rst.reg1", bus.dispatch_1st_reg_o, 64'd0);
    chk("rst.reg2", bus.dispatch_2nd_reg_o, 64'd0);
    chk("rst.rob", 64'(bus.dispatch_ROB_index_o), 64'd0);
    chk("rst.op", 64'(bus.dispatch_decoded_instruction_o), 64'd0);

    // ready issue: visible two edges later, for exactly one cycle
    issue(8'd5, 6'd1, 1'b1, 64'd6, 8'd0, 1'b1, 64'd7, 8'd0);
    tick(); bus.issue_valid_i = 1'b0;
    expect_out("ready.e1", 1'b0, 8'd0, 64'd0, 64'd0);
    tick();
    expect_out("ready.e2", 1'b1, 8'd5, 64'd6, 64'd7);
    tick();
    expect_out("ready.e3", 1'b0, 8'd0, 64'd0, 64'd0);

    // CDB wakeup three cycles after issue
    issue(8'd3, 6'd2, 1'b0, 64'd0, 8'd9, 1'b1, 64'd2, 8'd0);
    tick(); bus.issue_valid_i = 1'b0;
    tick(); tick();
    cdb(1'b1, 8'd9, 64'h10);
    tick(); cdb(1'b0, 8'd0, 64'd0);
    expect_out("wake.cap", 1'b0, 8'd0, 64'd0, 64'd0);
    tick();
    expect_out("wake.disp", 1'b1, 8'd3, 64'h10, 64'd2);
    tick();

    // same-cycle bypass at issue
    issue(8'd4, 6'd3, 1'b0, 64'd0, 8'd11, 1'b1, 64'd5, 8'd0);
    cdb(1'b1, 8'd11, 64'h33);
    tick(); bus.issue_valid_i = 1'b0; cdb(1'b0, 8'd0, 64'd0);
    expect_out("byp.e1", 1'b0, 8'd0, 64'd0, 64'd0);
    tick();
    expect_out("byp.e2", 1'b1, 8'd4, 64'h33, 64'd5);
    tick();

    // fill all slots waiting on tag 20, then wake them together
    for (int k = 1; k <= 4; k++) begin
      issue(8'(k), 6'd4, 1'b0, 64'd0, 8'd20, 1'b1, 64'(k * 100), 8'd0);
      tick();
    end
    bus.issue_valid_i = 1'b0;
    chk("full.ready", 64'(bus.issue_ready_o), 64'd0);
    issue(8'd9, 6'd5, 1'b1, 64'd1, 8'd0, 1'b1, 64'd2, 8'd0);
    tick();
    chk("full.stall", 64'(bus.issue_ready_o), 64'd0);
    tick(); bus.issue_valid_i = 1'b0;
    cdb(1'b1, 8'd20, 64'd1);
    tick(); cdb(1'b0, 8'd0, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      expect_out("age", 1'b1, 8'(k), 64'd1, 64'(k * 100));
    end
    chk("age.ready_back", 64'(bus.issue_ready_o), 64'd1);
    tick();
    expect_out("age.drain", 1'b0, 8'd0, 64'd0, 64'd0);

    // backpressure holds the older entry stable
    bus.dispatch_ready_i = 1'b0;
    issue(8'd7, 6'd6, 1'b1, 64'd10, 8'd0, 1'b1, 64'd11, 8'd0);
    tick();
    issue(8'd8, 6'd7, 1'b1, 64'd12, 8'd0, 1'b1, 64'd13, 8'd0);
    tick(); bus.issue_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_out("bp.hold", 1'b1, 8'd7, 64'd10, 64'd11);
      tick();
    end
    bus.dispatch_ready_i = 1'b1;
    expect_out("bp.rel0", 1'b1, 8'd7, 64'd10, 64'd11);
    tick();
    expect_out("bp.rel1", 1'b1, 8'd8, 64'd12, 64'd13);
    tick();
    expect_out("bp.rel2", 1'b0, 8'd0, 64'd0, 64'd0);

    // flush with three waiting slots, a valid output and a concurrent issue
    bus.dispatch_ready_i = 1'b0;
    issue(8'd24, 6'd1, 1'b1, 64'd1, 8'd0, 1'b1, 64'd2, 8'd0);
    tick();
    for (int k = 21; k <= 23; k++) begin
      issue(8'(k), 6'd2, 1'b0, 64'd0, 8'd30, 1'b1, 64'd3, 8'd0);
      tick();
    end
    expect_out("fl.pre", 1'b1, 8'd24, 64'd1, 64'd2);
    issue(8'd25, 6'd3, 1'b1, 64'd5, 8'd0, 1'b1, 64'd6, 8'd0);
    bus.flush_i = 1'b1; bus.dispatch_ready_i = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.issue_valid_i = 1'b0;
    chk("fl.valid", 64'(bus.dispatch_valid_o), 64'd0);
    chk("fl.ready", 64'(bus.issue_ready_o), 64'd1);
    chk("fl.reg1", bus.dispatch_1st_reg_o, 64'd0);
    chk("fl.rob", 64'(bus.dispatch_ROB_index_o), 64'd0);
    cdb(1'b1, 8'd30, 64'h99);
    tick(); cdb(1'b0, 8'd0, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl.quiet", 64'(bus.dispatch_valid_o), 64'd0);
    end

    // reset mid-operation with a valid output
    issue(8'd40, 6'd4, 1'b1, 64'd8, 8'd0, 1'b1, 64'd9, 8'd0);
    tick(); bus.issue_valid_i = 1'b0;
    tick();
    expect_out("rmid.pre", 1'b1, 8'd40, 64'd8, 64'd9);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rmid.valid", 64'(bus.dispatch_valid_o), 64'd0);
    chk("rmid.ready", 64'(bus.issue_ready_o), 64'd1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
